regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the dual-issue core.
//  Supports a configurable number of read and write ports, width and depth,
//  plus an optional hardwired zero register and optional write-to-read bypass.
//  After reset, a sweep FSM clears every entry to zero, one entry per cycle.
//  Sits between decode/issue (read) and writeback (write).
// PARAMETERS
//  WIDTH     32  data bits per entry
//  DEPTH     32  number of entries; must be a power of two >= 2 (elab assert)
//  NR         4  number of read ports
//  NW         2  number of write ports
//  ZERO_REG   1  1: entry 0 reads 0 and writes to it are dropped
//  BYPASS     0  1: same-cycle write data is forwarded to matching reads
//  AW        $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//  clk     in   1          clock, all state updates on posedge
//  reset   in   1          synchronous, active-high
//  raddr   in   NR*AW      packed [NR-1:0][AW-1:0] read addresses
//  rdata   out  NR*WIDTH   packed [NR-1:0][WIDTH-1:0] read data
//  we      in   NW         per-port write enable
//  waddr   in   NW*AW      packed [NW-1:0][AW-1:0] write addresses
//  wdata   in   NW*WIDTH   packed [NW-1:0][WIDTH-1:0] write data
//  ready   out  1          1 once the clear sweep has finished; writes accepted
// BEHAVIOUR
//  FSM states: CLEAR, READY. Pointer clr_ptr is AW bits wide.
//  - reset=1 (any state, including mid-sweep): next state CLEAR, clr_ptr<=0.
//    ready=0 on the cycle after reset is sampled.
//  - CLEAR: each cycle rf[clr_ptr]<=0 and clr_ptr<=clr_ptr+1. When
//    clr_ptr==DEPTH-1, next state is READY.
//    ready=0 for exactly DEPTH cycles after reset deasserts.
//  - CLEAR: all we[] are ignored and every rdata port returns 0.
//  - READY: terminal until the next reset. ready=1.
//  Reads: combinational, zero latency. rdata[i]=rf[raddr[i]].
//  Writes: for each port j with we[j]=1, rf[waddr[j]]<=wdata[j] on posedge.
//    The written value is visible to reads in the next cycle.
//  Write-write conflict: if ports share a waddr, the highest-index enabled
//    port wins. The other ports' data is discarded for that entry.
//  ZERO_REG=1: writes to address 0 are dropped. Reads of address 0 return 0,
//    including via bypass.
//  BYPASS=1: if any enabled port writes raddr[i] this cycle (READY only),
//    rdata[i] returns that port's wdata. On a conflict, the highest-index
//    port's wdata is forwarded.
//  BYPASS=0: same-cycle reads return the old stored value.
//  Reset value of outputs: ready=0. rdata=0 while in CLEAR.
//  No X may propagate from uninitialised storage: the sweep guarantees this.
// TESTING
//  1. Deassert reset, DEPTH=32 -> ready=0 for 32 cycles, then 1.
//     All 32 entries read 0 on every port.
//  2. In CLEAR, we[0]=1, waddr=5, wdata=0xDEAD -> ignored.
//     After ready=1, rdata for addr 5 = 0.
//  3. READY, we=2'b11, both waddr=7, wdata0=0x11, wdata1=0x22 ->
//     next cycle raddr=7 gives 0x22 on all 4 ports.
//  4. ZERO_REG=1, write 0xFFFF_FFFF to addr 0 -> addr 0 reads 0.
//     With BYPASS=1, the same-cycle read of addr 0 also gives 0.
//  5. BYPASS=1, we[1]=1, waddr=3, wdata=0xABCD, raddr[2]=3 same cycle ->
//     rdata[2]=0xABCD.
//     BYPASS=0, same stimulus -> old value, then 0xABCD next cycle.
//  6. Reset pulsed at clr_ptr=10 -> sweep restarts from 0.
//     ready stays low for a further 32 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with post-reset clear sweep, optional zero register and write bypass
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 4,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NR-1:0][AW-1:0]      raddr,
  output logic [NR-1:0][WIDTH-1:0]   rdata,
  input  logic [NW-1:0]              we,
  input  logic [NW-1:0][AW-1:0]      waddr,
  input  logic [NW-1:0][WIDTH-1:0]   wdata,
  output logic                       ready
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_mp: DEPTH must be a power of two >= 2");
  end
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [AW-1:0] clr_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] rf;
  always_comb begin
    state_n = (state == CLEAR && clr_ptr == AW'(DEPTH - 1)) ? READY : state;
  end
  assign ready = state == READY;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_n;
      if (state == CLEAR) begin
        rf[clr_ptr] <= '0;
        clr_ptr     <= clr_ptr + 1'b1;
      end else begin
        for (int j = 0; j < NW; j++)
          if (we[j] && !(ZERO_REG != 0 && waddr[j] == '0)) rf[waddr[j]] <= wdata[j];
      end
    end
  end
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic             hit;
    logic [WIDTH-1:0] fwd;
    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int j = 0; j < NW; j++)
        if (we[j] && waddr[j] == raddr[i]) begin
          hit = 1'b1;
          fwd = wdata[j];
        end
    end
    assign rdata[i] = (!ready || (ZERO_REG != 0 && raddr[i] == '0)) ? '0 :
                      (BYPASS != 0 && hit) ? fwd : rf[raddr[i]];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench comparing bypass and non-bypass register files against a reference model
module tb_regfile_mp;
  localparam int W = 32, D = 32, NR = 4, NW = 2, AW = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0][AW-1:0] raddr;
  logic [NW-1:0] we;
  logic [NW-1:0][AW-1:0] waddr;
  logic [NW-1:0][W-1:0] wdata;
  logic [NR-1:0][W-1:0] rd0, rd1;
  logic rdy0, rdy1;
  logic [W-1:0] mem [D];
  int cnt = 0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  regfile_mp #(.BYPASS(0)) dut0 (.clk(clk), .reset(reset), .raddr(raddr), .rdata(rd0),
    .we(we), .waddr(waddr), .wdata(wdata), .ready(rdy0));
  regfile_mp #(.BYPASS(1)) dut1 (.clk(clk), .reset(reset), .raddr(raddr), .rdata(rd1),
    .we(we), .waddr(waddr), .wdata(wdata), .ready(rdy1));
  function automatic logic [W-1:0] ref_rd(input logic [AW-1:0] a, input bit byp);
    if (cnt < D || a == '0) return '0;
    if (byp)
      for (int j = NW - 1; j >= 0; j--)
        if (we[j] && waddr[j] == a) return wdata[j];
    return mem[a];
  endfunction
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s.nb%0d", tag, i), rd0[i], ref_rd(raddr[i], 1'b0));
      check($sformatf("%s.byp%0d", tag, i), rd1[i], ref_rd(raddr[i], 1'b1));
    end
    check({tag, ".ready_nb"}, W'(rdy0), W'(cnt == D));
    check({tag, ".ready_byp"}, W'(rdy1), W'(cnt == D));
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      cnt = 0;
      foreach (mem[k]) mem[k] = '0;
    end else if (cnt == D) begin
      for (int j = 0; j < NW; j++)
        if (we[j] && waddr[j] != '0) mem[waddr[j]] = wdata[j];
    end else begin
      cnt++;
    end
    #1;
  endtask
  task automatic rnd();
    we = NW'($urandom);
    for (int j = 0; j < NW; j++) begin
      waddr[j] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D - 1));
      wdata[j] = $urandom;
    end
    for (int i = 0; i < NR; i++)
      raddr[i] = $urandom_range(0, 1) ? waddr[$urandom_range(0, NW - 1)] : AW'($urandom_range(0, D - 1));
  endtask
  initial begin
    we = '0; raddr = '0; waddr = '0; wdata = '0;
    tick(); tick();
    #2 check_all("reset");
    reset = 1'b0;
    for (int k = 0; k < D; k++) begin
      rnd();
      if (k == 0) begin
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hDEAD;
      end
      #2 check_all("clear");
      tick();
    end
    #2 check("ready_up", W'(rdy0), 32'd1);
    for (int k = 0; k < D / NR; k++) begin
      we = '0;
      for (int i = 0; i < NR; i++) raddr[i] = AW'(k * NR + i);
      #2 check_all("sweep");
      if (k == 1) check("addr5_ignored", rd0[1], 32'h0);
      tick();
    end
    we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7; wdata[0] = 32'h11; wdata[1] = 32'h22;
    for (int i = 0; i < NR; i++) raddr[i] = 5'd7;
    #2 check_all("conflict_wr");
    check("conflict_fwd", rd1[3], 32'h22);
    tick();
    we = '0;
    #2 check_all("conflict_rd");
    for (int i = 0; i < NR; i++) check("conflict", rd0[i], 32'h22);
    tick();
    we = 2'b01; waddr[0] = '0; wdata[0] = 32'hFFFF_FFFF;
    for (int i = 0; i < NR; i++) raddr[i] = '0;
    #2 check_all("zero_wr");
    check("zero_fwd", rd1[0], 32'h0);
    tick();
    we = '0;
    #2 check_all("zero_rd");
    check("zero", rd0[0], 32'h0);
    tick();
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h1234;
    tick();
    we = 2'b10; waddr[0] = 5'd9; waddr[1] = 5'd3; wdata[1] = 32'hABCD; raddr[2] = 5'd3;
    #2 check_all("bypass_wr");
    check("bypass_fwd", rd1[2], 32'hABCD);
    check("bypass_old", rd0[2], 32'h1234);
    tick();
    we = '0;
    #2 check("bypass_next", rd0[2], 32'hABCD);
    tick();
    for (int k = 0; k < 400; k++) begin
      rnd();
      #2 check_all("random");
      tick();
    end
    reset = 1'b1; we = '0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rnd();
      #2 check_all("sweep2");
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < D; k++) begin
      rnd();
      #2 check_all("restart");
      tick();
    end
    #2 check("ready_again", W'(rdy1), 32'd1);
    for (int k = 0; k < D / NR; k++) begin
      we = '0;
      for (int i = 0; i < NR; i++) raddr[i] = AW'(k * NR + i);
      #2 check_all("resweep");
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
